// File: rtl/pc_jump_unit_if.sv
// Control, jump-table write and status signals of pc_jump_unit.
// The driver uses the master modport; the PC unit uses the slave modport.
interface pc_jump_unit_if #(
   parameter int D = 12,
   parameter int N = 16
);
   localparam int IW = $clog2(N);

   logic          start;
   logic [D-1:0]  start_addr;
   logic          stall;
   logic          halt;
   logic          jump;
   logic          wr_en;
   logic [IW-1:0] wr_idx;
   logic [D-1:0]  wr_src;
   logic [D-1:0]  wr_val;
   logic          wr_abs;
   logic          wr_valid;
   logic [D-1:0]  pc;
   logic          running;
   logic          done;
   logic          miss;

   modport master (
      output start, start_addr, stall, halt, jump,
      output wr_en, wr_idx, wr_src, wr_val, wr_abs, wr_valid,
      input  pc, running, done, miss
   );

   modport slave (
      input  start, start_addr, stall, halt, jump,
      input  wr_en, wr_idx, wr_src, wr_val, wr_abs, wr_valid,
      output pc, running, done, miss
   );
endinterface

// File: rtl/pc_jump_unit.sv
// Program counter with IDLE/RUN/DONE sequencing and an N-entry jump table.
// Define PC_JUMP_MISS_TRAP_EN to make a jump-table miss stop execution (DONE).
module pc_jump_unit #(
   parameter int D = 12,
   parameter int N = 16
) (
   input logic           clk,
   input logic           rst_n,
   pc_jump_unit_if.slave bus
);
   localparam int IW = $clog2(N);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic [D-1:0]  pc_q, pc_nxt;
   logic          miss_q, miss_nxt;

   logic [N-1:0]  tbl_valid;
   logic [N-1:0]  tbl_abs;
   logic [D-1:0]  tbl_src [N];
   logic [D-1:0]  tbl_val [N];

   logic          hit;
   logic [IW-1:0] hit_idx;

   // Lowest matching valid entry wins; contents are the pre-write values.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (!hit && tbl_valid[i] && (tbl_src[i] == pc_q)) begin
            hit     = 1'b1;
            hit_idx = IW'(i);
         end
      end
   end

   always_comb begin
      // NOTE: every output of this block is defaulted first so no path infers a latch.
      state_nxt = state;
      pc_nxt    = pc_q;
      miss_nxt  = 1'b0;
      unique case (state)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               state_nxt = S_RUN;
               pc_nxt    = bus.start_addr;
            end
         end
         S_RUN: begin
            if (bus.halt) begin
               state_nxt = S_DONE;
            end else if (bus.start) begin
               pc_nxt = bus.start_addr;
            end else if (bus.stall) begin
               pc_nxt = pc_q;
            end else if (bus.jump) begin
               if (hit) begin
                  pc_nxt = tbl_abs[hit_idx] ? tbl_val[hit_idx] : pc_q + tbl_val[hit_idx];
               end else begin
                  miss_nxt = 1'b1;
`ifdef PC_JUMP_MISS_TRAP_EN
                  state_nxt = S_DONE;
`else
                  pc_nxt = pc_q + 1'b1;
`endif
               end
            end else begin
               pc_nxt = pc_q + 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         pc_q      <= '0;
         miss_q    <= 1'b0;
         tbl_valid <= '0;
      end else begin
         state  <= state_nxt;
         pc_q   <= pc_nxt;
         miss_q <= miss_nxt;
         if (bus.wr_en) begin
            tbl_valid[bus.wr_idx] <= bus.wr_valid;
         end
      end
   end

   // NOTE: entry payload stays unreset; the cleared valid bits make stale fields harmless.
   always_ff @(posedge clk) begin
      if (rst_n && bus.wr_en) begin
         tbl_src[bus.wr_idx] <= bus.wr_src;
         tbl_val[bus.wr_idx] <= bus.wr_val;
         tbl_abs[bus.wr_idx] <= bus.wr_abs;
      end
   end

   assign bus.pc      = pc_q;
   assign bus.running = (state == S_RUN);
   assign bus.done    = (state == S_DONE);
   assign bus.miss    = miss_q;
endmodule

// File: tb/tb_pc_jump_unit.sv
// Self-checking bench for pc_jump_unit: directed scenarios then random traffic,
// all compared against a behavioural model of the PC/jump-table rules.
module tb_pc_jump_unit;
   localparam int D  = 12;
   localparam int N  = 16;
   localparam int IW = $clog2(N);
   localparam int M  = 1 << D;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   pc_jump_unit_if #(.D(D), .N(N)) bus ();

   pc_jump_unit #(.D(D), .N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   typedef enum {M_IDLE, M_RUN, M_DONE} mstate_t;
   mstate_t m_state = M_IDLE;
   int      m_pc    = 0;
   bit      m_miss  = 1'b0;
   bit      t_valid [N];
   int      t_src   [N];
   int      t_val   [N];
   bit      t_abs   [N];

   function automatic int wrap(input int x);
      return ((x % M) + M) % M;
   endfunction

   function automatic int as_signed(input int v);
      return (v >= M / 2) ? v - M : v;
   endfunction

   // Reference behaviour for one rising edge, using the inputs currently driven.
   task automatic model_step();
      int      hit_i;
      int      np;
      mstate_t ns;
      bit      nmiss;
      if (!rst_n) begin
         m_state = M_IDLE;
         m_pc    = 0;
         m_miss  = 1'b0;
         for (int i = 0; i < N; i++) t_valid[i] = 1'b0;
         return;
      end
      hit_i = -1;
      for (int i = 0; i < N; i++)
         if (hit_i < 0 && t_valid[i] && t_src[i] == m_pc) hit_i = i;
      np    = m_pc;
      ns    = m_state;
      nmiss = 1'b0;
      case (m_state)
         M_IDLE, M_DONE: if (bus.start) begin ns = M_RUN; np = int'(bus.start_addr); end
         M_RUN: begin
            if (bus.halt) ns = M_DONE;
            else if (bus.start) np = int'(bus.start_addr);
            else if (bus.stall) np = m_pc;
            else if (bus.jump) begin
               if (hit_i >= 0)
                  np = t_abs[hit_i] ? t_val[hit_i] : wrap(m_pc + as_signed(t_val[hit_i]));
               else begin
                  nmiss = 1'b1;
`ifdef PC_JUMP_MISS_TRAP_EN
                  ns = M_DONE;
`else
                  np = wrap(m_pc + 1);
`endif
               end
            end else np = wrap(m_pc + 1);
         end
         default: ns = M_IDLE;
      endcase
      if (bus.wr_en) begin
         t_valid[bus.wr_idx] = bus.wr_valid;
         t_src[bus.wr_idx]   = int'(bus.wr_src);
         t_val[bus.wr_idx]   = int'(bus.wr_val);
         t_abs[bus.wr_idx]   = bus.wr_abs;
      end
      m_state = ns;
      m_pc    = np;
      m_miss  = nmiss;
   endtask

   task automatic check(input string tag, input logic [D-1:0] obs, input logic [D-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic compare_model(input string tag);
      logic [D-1:0] exp_pc;
      exp_pc = m_pc[D-1:0];
      check({tag, " pc"},      bus.pc,             exp_pc);
      check({tag, " running"}, D'(bus.running),    D'(m_state == M_RUN));
      check({tag, " done"},    D'(bus.done),       D'(m_state == M_DONE));
      check({tag, " miss"},    D'(bus.miss),       D'(m_miss));
   endtask

   task automatic tick(input string tag);
      model_step();
      @(posedge clk);
      #1;
      compare_model(tag);
   endtask

   task automatic idle_inputs();
      bus.start = 1'b0; bus.start_addr = '0; bus.stall = 1'b0; bus.halt = 1'b0;
      bus.jump = 1'b0; bus.wr_en = 1'b0; bus.wr_idx = '0; bus.wr_src = '0;
      bus.wr_val = '0; bus.wr_abs = 1'b0; bus.wr_valid = 1'b0;
   endtask

   task automatic tbl_write(input int idx, input int src, input int val, input bit abs_m, input bit vld);
      bus.wr_en    = 1'b1;
      bus.wr_idx   = IW'(idx);
      bus.wr_src   = D'(src);
      bus.wr_val   = D'(val);
      bus.wr_abs   = abs_m;
      bus.wr_valid = vld;
   endtask

   task automatic start_at(input int addr);
      bus.start = 1'b1; bus.start_addr = D'(addr);
      tick("start");
      bus.start = 1'b0;
   endtask

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      tick("reset");
      tick("reset");
      check("reset pc", bus.pc, 12'h000);
      check("reset running", D'(bus.running), 12'h000);
      rst_n = 1'b1;

      // Start at 0x004, then three sequential steps.
      start_at(12'h004);
      check("start pc", bus.pc, 12'h004);
      check("start running", D'(bus.running), 12'h001);
      for (int i = 1; i <= 3; i++) begin
         tick("seq");
         check("seq pc", bus.pc, D'(4 + i));
      end

      // Load the table while stalled; PC must not move.
      bus.stall = 1'b1;
      tbl_write(0, 12'h006, 12'hFFB, 1'b0, 1'b1);
      tick("wr e0");
      check("write keeps pc", bus.pc, 12'h007);
      tbl_write(3, 12'h010, 12'h123, 1'b1, 1'b1);
      tick("wr e3");
      tbl_write(1, 12'h010, 12'h014, 1'b0, 1'b1);
      tick("wr e1");
      bus.wr_en = 1'b0;
      bus.stall = 1'b0;

      // Relative backward jump: 0x006 + (-5) = 0x001.
      start_at(12'h006);
      bus.jump = 1'b1;
      tick("rel jump");
      check("rel jump pc", bus.pc, 12'h001);
      check("rel jump miss", D'(bus.miss), 12'h000);
      bus.jump = 1'b0;

      // Two entries match 0x010; entry1 (relative +0x14) beats entry3.
      start_at(12'h010);
      bus.jump = 1'b1;
      tick("prio jump");
      check("prio jump pc", bus.pc, 12'h024);
      bus.jump = 1'b0;

      // PC wrap from 0xFFF to 0x000.
      start_at(12'hFFE);
      tick("pre wrap");
      tick("wrap");
      check("wrap pc", bus.pc, 12'h000);

      // Jump at an unmatched address.
      start_at(12'h020);
      bus.jump = 1'b1;
      tick("miss");
      check("miss pulse", D'(bus.miss), 12'h001);
`ifdef PC_JUMP_MISS_TRAP_EN
      check("miss trap pc", bus.pc, 12'h020);
      check("miss trap done", D'(bus.done), 12'h001);
`else
      check("miss seq pc", bus.pc, 12'h021);
`endif
      bus.jump = 1'b0;
      tick("miss end");
      check("miss one cycle", D'(bus.miss), 12'h000);

      // Reset in the middle of execution.
      start_at(12'h030);
      tick("run");
      rst_n = 1'b0;
      tick("midrun reset");
      check("midrun reset pc", bus.pc, 12'h000);
      check("midrun reset running", D'(bus.running), 12'h000);
      rst_n = 1'b1;

      // Entries that matched 0x010 before reset must now miss.
      start_at(12'h010);
      bus.jump = 1'b1;
      tick("post reset lookup");
      check("post reset miss", D'(bus.miss), 12'h001);
      bus.jump = 1'b0;

      // Same-cycle write is invisible to the lookup; next visit hits.
      start_at(12'h008);
      bus.jump = 1'b1;
      tbl_write(0, 12'h008, 12'h002, 1'b0, 1'b1);
      tick("same cycle write");
      check("same cycle miss", D'(bus.miss), 12'h001);
      bus.wr_en = 1'b0;
      bus.jump  = 1'b0;
      start_at(12'h008);
      bus.jump = 1'b1;
      tick("revisit");
      check("revisit pc", bus.pc, 12'h00A);
      bus.jump = 1'b0;

      // Halt beats start; halt in DONE has no effect.
      bus.halt = 1'b1; bus.start = 1'b1; bus.start_addr = 12'h100;
      tick("halt+start");
      check("halt+start done", D'(bus.done), 12'h001);
      check("halt+start pc", bus.pc, 12'h00A);
      bus.start = 1'b0;
      tick("halt in done");
      check("halt in done pc", bus.pc, 12'h00A);
      bus.halt = 1'b0;

      // Stall suppresses a jump that would otherwise hit.
      start_at(12'h008);
      bus.stall = 1'b1; bus.jump = 1'b1;
      tick("stall+jump");
      check("stall+jump pc", bus.pc, 12'h008);
      check("stall+jump miss", D'(bus.miss), 12'h000);
      idle_inputs();

      // Random traffic, table sources biased near the current PC to produce hits.
      for (int c = 0; c < 600; c++) begin
         rst_n          = ($urandom % 90) != 0;
         bus.start      = ($urandom % 10) == 0;
         bus.start_addr = ($urandom % 2) ? D'($urandom) : D'(m_pc + $urandom_range(0, 3));
         bus.halt       = ($urandom % 25) == 0;
         bus.stall      = ($urandom % 6) == 0;
         bus.jump       = ($urandom % 3) == 0;
         bus.wr_en      = ($urandom % 3) == 0;
         bus.wr_idx     = IW'($urandom);
         bus.wr_src     = D'(m_pc + $urandom_range(0, 3));
         bus.wr_val     = ($urandom % 2) ? D'($urandom_range(0, 7)) : D'($urandom);
         bus.wr_abs     = $urandom % 2;
         bus.wr_valid   = ($urandom % 5) != 0;
         tick($sformatf("rand%0d", c));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/pc_jump_unit.md
PC_JUMP_UNIT -- requirements
Module: pc_jump_unit

Interface
REQ-001 Parameter D, default 12: PC width in bits; all PC arithmetic is modulo 2^D.
REQ-002 Parameter N, default 16: jump-table entries; N is a power of two, >= 2; IW = log2(N).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 start  input  1  begin or restart execution at start_addr.
REQ-006 start_addr  input  D  PC loaded on an accepted start.
REQ-007 stall  input  1  hold PC this cycle while RUN.
REQ-008 halt  input  1  stop execution; enter DONE.
REQ-009 jump  input  1  current instruction is a jump; look up PC in table.
REQ-010 wr_en  input  1  table write strobe.
REQ-011 wr_idx  input  IW  table entry to write.
REQ-012 wr_src  input  D  PC of the jump instruction stored in the entry.
REQ-013 wr_val  input  D  signed offset (relative) or target (absolute).
REQ-014 wr_abs  input  1  entry mode: 1 = absolute, 0 = relative.
REQ-015 wr_valid  input  1  valid bit written; 0 invalidates the entry.
REQ-016 pc  output  D  current program counter.
REQ-017 running  output  1  high in RUN.
REQ-018 done  output  1  high in DONE.
REQ-019 miss  output  1  one-cycle pulse: jump with no matching valid entry.

Function
REQ-020 FSM states: IDLE, RUN, DONE; running = (state==RUN), done = (state==DONE).
REQ-021 IDLE: PC held; start -> RUN with pc <= start_addr on the same edge.
REQ-022 RUN, priority halt > start > stall > jump > sequential.
REQ-023 RUN + halt -> DONE; PC frozen at its current value.
REQ-024 RUN + start (no halt) -> stays RUN; pc <= start_addr.
REQ-025 RUN + stall: pc held, jump ignored, miss stays 0.
REQ-026 RUN, no jump: pc <= pc + 1, wrapping 2^D-1 -> 0.
REQ-027 RUN + jump: search all valid entries combinationally for wr_src == pc; lowest index wins on multiple matches.
REQ-028 Hit, relative entry: pc <= pc + val (val two's-complement, D bits, modulo 2^D); offset 0 holds PC.
REQ-029 Hit, absolute entry: pc <= val.
REQ-030 Miss: behaviour per REQ-037/038; miss pulses high for the cycle following the jump edge.
REQ-031 DONE: PC held; start -> RUN with pc <= start_addr; halt has no effect.
REQ-032 Table write takes effect at the edge where wr_en is sampled, in any state; a lookup in that same cycle uses pre-write contents.
REQ-033 Table writes do not alter state, pc or miss.

Reset
REQ-034 rst_n low at an edge: state <= IDLE, pc <= 0, miss <= 0, all entry valid bits <= 0; overrides every other input.
REQ-035 Entry src/val/mode fields are not reset.
REQ-036 Reset mid-RUN aborts execution; table must be rewritten before jumps hit.

Configuration
REQ-037 Macro PC_JUMP_MISS_TRAP_EN defined: jump miss in RUN -> DONE, pc held at the jump PC, miss pulses.
REQ-038 Macro undefined: jump miss -> pc <= pc + 1, state stays RUN, miss pulses.

Verification
REQ-039 Reset, start with start_addr=0x004, 3 idle cycles -> pc 0x004,0x005,0x006,0x007; running=1.
REQ-040 D=12, entry0 {src=0x006, val=0xFFB, rel, valid}, jump at pc=0x006 -> next pc 0x001; miss=0.
REQ-041 Entry3 {src=0x010, val=0x123, abs} plus entry1 same src {val=0x014, rel}; jump at 0x010 -> pc 0x024 (entry1 wins).
REQ-042 pc=0xFFF, no jump -> pc 0x000; jump at unmatched 0x020 -> miss=1 one cycle, pc 0x021 (macro off) or DONE with pc 0x020 (macro on).
REQ-043 Same-cycle write entry0 {src=0x008, val=0x002, rel} while jump at pc=0x008 on empty table -> treated as miss; next visit to 0x008 -> pc 0x00A.
REQ-044 halt and start together in RUN -> DONE, pc frozen; stall+jump -> pc held, miss=0; rst_n low mid-RUN -> pc 0, IDLE, table invalid.
